// File: rtl/bus_latch_sequencer.sv
// Upstream sequencer for the latch bank. It runs one bus transfer per request:
// optional wait states, a single CE/data strobe, then a single acknowledge.
module bus_latch_sequencer #(
  parameter int WIDTH  = 16,
  parameter int WAIT_W = 4
) (
  input  logic              C,
  input  logic              CLR,
  input  logic              START,
  input  logic              RW,
  input  logic [WAIT_W-1:0] WAIT,
  input  logic              ABORT,
  input  logic [WIDTH-1:0]  BUS_D,
  input  logic [WIDTH-1:0]  CPU_D,
  output logic              LATCH_CE,
  output logic [WIDTH-1:0]  LATCH_D,
  output logic              ACK,
  output logic              BUSY
);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_WAIT  = 5'b00010,
    S_LATCH = 5'b00100,
    S_ACK   = 5'b01000,
    S_HOLD  = 5'b10000
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_cnt;
  logic [WAIT_W-1:0] w_cnt_nxt;
  logic              r_rw;
  logic              w_rw_nxt;
  logic [WIDTH-1:0]  r_latch_d;
  logic [WIDTH-1:0]  w_latch_d_nxt;

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rw      <= 1'b1;
      r_latch_d <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rw      <= w_rw_nxt;
      r_latch_d <= w_latch_d_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rw_nxt      = r_rw;
    w_latch_d_nxt = r_latch_d;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = WAIT;
          w_rw_nxt    = RW;
          // Write data is frozen at request time so later CPU_D changes are ignored.
          if (!RW) w_latch_d_nxt = CPU_D;
        end
      end
      S_WAIT: begin
        if (ABORT) begin
          w_state_nxt = S_HOLD;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - WAIT_W'(1);
        end else begin
          w_state_nxt = S_LATCH;
          if (r_rw) w_latch_d_nxt = BUS_D;
        end
      end
      S_LATCH: w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_HOLD;
      S_HOLD: begin
        // Requester must release START before another transfer can begin.
        if (!START) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign LATCH_CE = (r_state == S_LATCH);
  assign ACK      = (r_state == S_ACK);
  assign BUSY     = (r_state != S_IDLE);
  assign LATCH_D  = r_latch_d;

endmodule
